// File: rtl/dest_data_seq_mux.sv
// Destination data sequence mux.
// Takes one {pid, len, dest} sequence entry at a time. For each entry it passes
// exactly len+1 beats from s_axis[dest] through to m_axis with no added latency.
// tlast is generated from the beat count; the source tlast is not used.
// Entries are served strictly in the order they are accepted.
// Optional feature: define DEST_MUX_B2B_EN to accept the next entry in the same
// cycle as the last beat of the current one, so transfers run back-to-back.
module dest_data_seq_mux #(
    parameter int unsigned DATA_BITS = 512,
    parameter int unsigned N_DESTS   = 4,
    parameter int unsigned PID_BITS  = 6,
    parameter int unsigned LEN_BITS  = 28,
    localparam int unsigned DEST_BITS = (N_DESTS > 1) ? $clog2(N_DESTS) : 1,
    localparam int unsigned KEEP_BITS = DATA_BITS / 8
) (
    input  logic                           aclk,
    input  logic                           aresetn,
    input  logic                           seq_valid_i,
    output logic                           seq_ready_o,
    input  logic [PID_BITS-1:0]            seq_pid_i,
    input  logic [LEN_BITS-1:0]            seq_len_i,
    input  logic [DEST_BITS-1:0]           seq_dest_i,
    input  logic [N_DESTS-1:0]             s_axis_tvalid_i,
    output logic [N_DESTS-1:0]             s_axis_tready_o,
    input  logic [N_DESTS*DATA_BITS-1:0]   s_axis_tdata_i,
    input  logic [N_DESTS*KEEP_BITS-1:0]   s_axis_tkeep_i,
    output logic                           m_axis_tvalid_o,
    input  logic                           m_axis_tready_i,
    output logic [DATA_BITS-1:0]           m_axis_tdata_o,
    output logic [KEEP_BITS-1:0]           m_axis_tkeep_o,
    output logic                           m_axis_tlast_o,
    output logic [PID_BITS-1:0]            m_axis_tid_o,
    output logic                           err_dest_o
);

    typedef enum logic {StIdle, StXfer} state_e;

    state_e                state_q;
    logic [LEN_BITS-1:0]   cnt_q;
    logic [DEST_BITS-1:0]  dest_q;
    logic [PID_BITS-1:0]   pid_q;
    logic                  err_dest_q;

    logic                  xfer;
    logic                  cnt_zero;
    logic                  beat_hs;
    logic                  seq_hs;
    logic                  seq_dest_ok;
    logic                  sel_valid;
    logic [DATA_BITS-1:0]  sel_data;
    logic [KEEP_BITS-1:0]  sel_keep;

    // Checked at full width so an out-of-range index is caught for any N_DESTS.
    assign seq_dest_ok = 32'(seq_dest_i) < N_DESTS;

    // Select the active source's valid, data and keep.
    always_comb begin
        sel_valid = 1'b0;
        sel_data  = '0;
        sel_keep  = '0;
        for (int unsigned i = 0; i < N_DESTS; i++) begin
            if (32'(dest_q) == i) begin
                sel_valid = s_axis_tvalid_i[i];
                sel_data  = s_axis_tdata_i[i*DATA_BITS +: DATA_BITS];
                sel_keep  = s_axis_tkeep_i[i*KEEP_BITS +: KEEP_BITS];
            end
        end
    end

    // Pass-through handshake. All handshakes are gated by aresetn so that
    // nothing can transfer while reset is held, because reset only takes
    // effect at the next clock edge.
    always_comb begin
        xfer            = aresetn && (state_q == StXfer);
        cnt_zero        = (cnt_q == '0);
        m_axis_tvalid_o = xfer && sel_valid;
        beat_hs         = m_axis_tvalid_o && m_axis_tready_i;
        m_axis_tlast_o  = xfer && cnt_zero;
        m_axis_tdata_o  = sel_data;
        m_axis_tkeep_o  = sel_keep;
        m_axis_tid_o    = pid_q;
        for (int unsigned i = 0; i < N_DESTS; i++) begin
            s_axis_tready_o[i] = xfer && m_axis_tready_i && (32'(dest_q) == i);
        end
`ifdef DEST_MUX_B2B_EN
        seq_ready_o = (aresetn && (state_q == StIdle)) || (xfer && cnt_zero && beat_hs);
`else
        seq_ready_o = aresetn && (state_q == StIdle);
`endif
        seq_hs      = seq_valid_i && seq_ready_o;
        err_dest_o  = err_dest_q;
    end

    // Sequencer FSM: latch entries, count beats, flag bad destinations.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            dest_q     <= '0;
            pid_q      <= '0;
            err_dest_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (seq_hs) begin
                        if (seq_dest_ok) begin
                            dest_q  <= seq_dest_i;
                            pid_q   <= seq_pid_i;
                            cnt_q   <= seq_len_i;
                            state_q <= StXfer;
                        end else begin
                            err_dest_q <= 1'b1;
                        end
                    end
                end
                StXfer: begin
                    if (beat_hs) begin
                        if (!cnt_zero) begin
                            cnt_q <= cnt_q - LEN_BITS'(1);
                        end else begin
`ifdef DEST_MUX_B2B_EN
                            // Last beat: reload in place when the next entry is ready.
                            if (seq_hs && seq_dest_ok) begin
                                dest_q <= seq_dest_i;
                                pid_q  <= seq_pid_i;
                                cnt_q  <= seq_len_i;
                            end else begin
                                if (seq_hs) begin
                                    err_dest_q <= 1'b1;
                                end
                                state_q <= StIdle;
                            end
`else
                            state_q <= StIdle;
`endif
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
